psram_line_cache: RTL and testbench

//  Direct-mapped, write-back cache between the RISC5 CPU data port and the QSPI PSRAM controller.
//  - Serves 32-bit CPU loads/stores from an on-chip line store.
//  - On a miss it writes back the dirty victim line, then fills the missing line.
//  - Each line is 64 B, transferred to/from the controller as four 128-bit beats over its
//    mem_rd/mem_wr, busy, cache_en/we/addr interface.

---
 rtl/psram_cache_pkg.sv | 24 ++
 rtl/psram_cache_ram.sv | 49 ++++
 rtl/psram_line_cache.sv | 205 ++++++++++++++++++++
 tb/tb_psram_line_cache.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_cache_pkg.sv
// Shared constants, FSM state codes and geometry helpers for the PSRAM line cache.
package psram_cache_pkg;

  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned BEATS      = 4;
  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned LINE_W     = ADDR_W - $clog2(LINE_BYTES);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdOut  = 3'd1;
  localparam logic [2:0] StWbReq  = 3'd2;
  localparam logic [2:0] StWbWait = 3'd3;
  localparam logic [2:0] StFlReq  = 3'd4;
  localparam logic [2:0] StFlWait = 3'd5;

  function automatic int unsigned idx_w(input int unsigned nlines);
    return $clog2(nlines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned nlines);
    return LINE_W - $clog2(nlines);
  endfunction

endpackage

// File: rtl/psram_cache_ram.sv
// Line store: 128-bit dual-port RAM. Port A serves the CPU (byte-enabled write, read);
// port B serves controller beats. Both reads are registered, one cycle.
module psram_cache_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          a_re_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [15:0]   a_ben_i,
  input  logic [127:0]  a_wdata_i,
  output logic [127:0]  a_rdata_o,
  input  logic          b_en_i,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [127:0]  b_wdata_i,
  output logic [127:0]  b_rdata_o
);

  logic [127:0] mem_q [DEPTH];
  logic [127:0] a_rdata_q;
  logic [127:0] b_rdata_q;

  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      for (int i = 0; i < 16; i++) begin
        if (a_ben_i[i]) mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
      end
    end
    if (b_en_i && b_we_i) mem_q[b_addr_i] <= b_wdata_i;
  end

  // Read registers are reset so the cache outputs start at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re_i)             a_rdata_q <= mem_q[a_addr_i];
      if (b_en_i && !b_we_i)  b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/psram_line_cache.sv
// Direct-mapped write-back cache between the CPU data port and the QSPI PSRAM controller.
// Define PSRAM_CACHE_STATS_EN to add hit_cnt/miss_cnt statistics outputs.
module psram_line_cache
  import psram_cache_pkg::*;
#(
  parameter int unsigned NLINES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_rd,
  input  logic         cpu_wr,
  input  logic [21:0]  cpu_adr,
  input  logic [3:0]   cpu_ben,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_stall,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [17:0]  raddr,
  output logic [17:0]  waddr,
  output logic [127:0] cache_rdata,
  input  logic [127:0] cache_wdata,
  input  logic         cache_en,
  input  logic         cache_we,
  input  logic [1:0]   cache_addr,
  input  logic         rd_busy,
  input  logic         wr_busy
`ifdef PSRAM_CACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int unsigned IW = idx_w(NLINES);
  localparam int unsigned TW = tag_w(NLINES);
  localparam int unsigned AW = IW + 2;

  logic [2:0]        state_q, state_d;
  logic [21:0]       req_adr_q, req_adr_d;
  logic [17:0]       raddr_q, raddr_d, waddr_q, waddr_d;
  logic [NLINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TW-1:0]     tag_q [NLINES];
  logic [TW-1:0]     tag_d [NLINES];

  logic [TW-1:0] cur_tag, req_tag;
  logic [IW-1:0] cur_idx, req_idx;
  logic          hit, fill_open, wb_open;
  logic          ram_a_re, ram_a_we, ram_b_en;
  logic [15:0]   ram_a_ben;
  logic [127:0]  ram_a_rdata;

  assign cur_tag = cpu_adr[21 -: TW];
  assign cur_idx = cpu_adr[4 +: IW];
  assign req_tag = req_adr_q[21 -: TW];
  assign req_idx = req_adr_q[4 +: IW];
  assign hit     = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

  always_comb begin
    state_d   = state_q;
    req_adr_d = req_adr_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    tag_d     = tag_q;
    cpu_stall = 1'b0;
    ram_a_re  = 1'b0;
    ram_a_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cpu_rd || cpu_wr) begin
          req_adr_d = cpu_adr;
          if (hit) begin
            if (cpu_wr) begin
              ram_a_we         = 1'b1;
              dirty_d[cur_idx] = 1'b1;
            end else begin
              cpu_stall = 1'b1;
              ram_a_re  = 1'b1;
              state_d   = StRdOut;
            end
          end else begin
            cpu_stall = 1'b1;
            if (valid_q[cur_idx] && dirty_q[cur_idx]) begin
              waddr_d = {tag_q[cur_idx], cur_idx};
              state_d = StWbReq;
            end else begin
              raddr_d = cpu_adr[21:4];
              state_d = StFlReq;
            end
          end
        end
      end
      StRdOut: state_d = StIdle;
      StWbReq: begin
        cpu_stall = 1'b1;
        if (wr_busy) state_d = StWbWait;
      end
      StWbWait: begin
        cpu_stall = 1'b1;
        if (!wr_busy) begin
          dirty_d[req_idx] = 1'b0;
          raddr_d          = req_adr_q[21:4];
          state_d          = StFlReq;
        end
      end
      StFlReq: begin
        cpu_stall = 1'b1;
        if (rd_busy) state_d = StFlWait;
      end
      StFlWait: begin
        cpu_stall = 1'b1;
        if (!rd_busy) begin
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      req_adr_q <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_adr_q <= req_adr_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
    end
  end

  // Tags are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign fill_open = (state_q == StFlReq) || (state_q == StFlWait);
  assign wb_open   = (state_q == StWbReq) || (state_q == StWbWait);
  assign ram_b_en  = cache_en && (cache_we ? fill_open : wb_open);
  assign ram_a_ben = {12'b0, cpu_ben} << {cpu_adr[1:0], 2'b00};

  psram_cache_ram #(
    .DEPTH(NLINES * BEATS),
    .AW   (AW)
  ) u_ram (
    .clk_i    (clk),
    .rst_i    (reset),
    .a_re_i   (ram_a_re),
    .a_we_i   (ram_a_we),
    .a_addr_i ({cur_idx, cpu_adr[3:2]}),
    .a_ben_i  (ram_a_ben),
    .a_wdata_i({4{cpu_wdata}}),
    .a_rdata_o(ram_a_rdata),
    .b_en_i   (ram_b_en),
    .b_we_i   (cache_we),
    .b_addr_i ({req_idx, cache_addr}),
    .b_wdata_i(cache_wdata),
    .b_rdata_o(cache_rdata)
  );

  assign cpu_rdata = ram_a_rdata[{req_adr_q[1:0], 5'b0} +: 32];
  assign mem_rd    = (state_q == StFlReq);
  assign mem_wr    = (state_q == StWbReq);
  assign raddr     = raddr_q;
  assign waddr     = waddr_q;

`ifdef PSRAM_CACHE_STATS_EN
  logic        refill_q, lookup;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // The re-lookup right after a fill is the tail of a counted miss.
  always_comb begin
    lookup     = (state_q == StIdle) && (cpu_rd || cpu_wr);
    hit_cnt_d  = hit_cnt_q + ((lookup && hit && !refill_q) ? 32'd1 : 32'd0);
    miss_cnt_d = miss_cnt_q + ((lookup && !hit) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      refill_q   <= (state_q == StFlWait) && !rd_busy;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_psram_line_cache.sv
// Bench for psram_line_cache: PSRAM controller/memory model, flat-memory reference, scoreboards.
module tb_psram_line_cache;

  localparam int unsigned NL = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_rd, cpu_wr;
  logic [21:0]  cpu_adr;
  logic [3:0]   cpu_ben;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_stall, mem_rd, mem_wr;
  logic [17:0]  raddr, waddr;
  logic [127:0] cache_rdata, cache_wdata;
  logic         cache_en, cache_we;
  logic [1:0]   cache_addr;
  logic         rd_busy, wr_busy;
`ifdef PSRAM_CACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  psram_line_cache #(.NLINES(NL)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_adr    (cpu_adr),
    .cpu_ben    (cpu_ben),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .raddr      (raddr),
    .waddr      (waddr),
    .cache_rdata(cache_rdata),
    .cache_wdata(cache_wdata),
    .cache_en   (cache_en),
    .cache_we   (cache_we),
    .cache_addr (cache_addr),
    .rd_busy    (rd_busy),
    .wr_busy    (wr_busy)
`ifdef PSRAM_CACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          is_load;
    bit          hit;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    bit          is_wr;
    logic [17:0] ln;
  } xfer_t;

  exp_t  exp_q [$];
  xfer_t xfer_q [$];

  int unsigned n_pass = 0, n_total = 0, overlap = 0;

  // Reference: flat word memory plus which line each index holds and whether it was stored to.
  logic [31:0] psram_w [int unsigned];
  logic [31:0] gold_w  [int unsigned];
  int          m_tag   [NL];
  bit          m_dirty [NL];
  int unsigned m_hits = 0, m_misses = 0;

  function automatic logic [31:0] pattern(input int unsigned wa);
    return (wa * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] psram_rd(input int unsigned wa);
    return psram_w.exists(wa) ? psram_w[wa] : pattern(wa);
  endfunction

  function automatic logic [31:0] gold_rd(input int unsigned wa);
    return gold_w.exists(wa) ? gold_w[wa] : pattern(wa);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_access(input int unsigned wa, input bit store, input logic [3:0] ben,
                              input logic [31:0] wd, output bit hit, output logic [31:0] data);
    int unsigned ln, idx;
    ln  = wa >> 4;
    idx = ln % NL;
    hit = (m_tag[idx] == int'(ln));
    if (hit) begin
      m_hits++;
    end else begin
      m_misses++;
      if (m_tag[idx] >= 0 && m_dirty[idx]) xfer_q.push_back('{is_wr: 1'b1, ln: 18'(m_tag[idx])});
      xfer_q.push_back('{is_wr: 1'b0, ln: 18'(ln)});
      m_tag[idx]   = int'(ln);
      m_dirty[idx] = 1'b0;
    end
    data = gold_rd(wa);
    if (store) begin
      for (int i = 0; i < 4; i++) if (ben[i]) data[8*i +: 8] = wd[8*i +: 8];
      gold_w[wa]   = data;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NL); i++) begin
      m_tag[i]   = -1;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!cpu_stall) return;
    end
    n_total++;
    $display("FAIL req_timeout: cpu_stall still 1 after 400 cycles, expected 0");
    finish_run();
  endtask

  task automatic do_req(input bit rd, input bit wr, input int unsigned wa,
                        input logic [3:0] ben, input logic [31:0] wd);
    bit          hit;
    logic [31:0] data;
    exp_t        e;
    model_access(wa, wr, ben, wd, hit, data);
    @(posedge clk); #1;
    e.is_load = !wr;
    e.hit     = hit;
    e.data    = data;
    exp_q.push_back(e);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_adr   = 22'(wa);
    cpu_ben   = ben;
    cpu_wdata = wd;
    wait_done();
  endtask

  task automatic idle();
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  // Controller + PSRAM model: one line transfer per request, four beats, busy around it.
  task automatic ctl_fill();
    logic [17:0] ln;
    ln      = raddr;
    rd_busy = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      if (reset) begin
        cache_en = 1'b0;
        rd_busy  = 1'b0;
        return;
      end
      cache_en   = 1'b1;
      cache_we   = 1'b1;
      cache_addr = 2'(b);
      for (int l = 0; l < 4; l++)
        cache_wdata[32*l +: 32] = psram_rd(int'(ln) * 16 + b * 4 + l);
    end
    @(posedge clk); #1;
    cache_en = 1'b0;
    cache_we = 1'b0;
    rd_busy  = 1'b0;
  endtask

  task automatic ctl_wb();
    logic [17:0] ln;
    ln      = waddr;
    wr_busy = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      if (reset) begin
        cache_en = 1'b0;
        wr_busy  = 1'b0;
        return;
      end
      cache_en   = 1'b1;
      cache_we   = 1'b0;
      cache_addr = 2'(b);
      @(posedge clk); #1;
      cache_en = 1'b0;
      if (reset) begin
        wr_busy = 1'b0;
        return;
      end
      for (int l = 0; l < 4; l++)
        psram_w[int'(ln) * 16 + b * 4 + l] = cache_rdata[32*l +: 32];
    end
    @(posedge clk); #1;
    wr_busy = 1'b0;
  endtask

  initial begin : controller
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        if (mem_wr) ctl_wb();
        else if (mem_rd) ctl_fill();
      end
    end
  end

  initial begin : cpu_monitor
    int   lat;
    exp_t e;
    lat = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        lat = 0;
      end else if (cpu_rd || cpu_wr) begin
        lat++;
        if (!cpu_stall) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_completion: adr %0h completed, expected no request", cpu_adr);
          end else begin
            e = exp_q.pop_front();
            if (e.is_load) check("load_data", cpu_rdata, e.data);
            if (e.hit) check("hit_latency", lat, e.is_load ? 2 : 1);
          end
          lat = 0;
        end
      end
    end
  end

  initial begin : xfer_monitor
    bit    prd, pwr;
    xfer_t x;
    prd = 1'b0;
    pwr = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd && mem_wr) overlap++;
      if (!reset && ((mem_wr && !pwr) || (mem_rd && !prd))) begin
        if (xfer_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_xfer: mem_wr=%0b mem_rd=%0b, expected no PSRAM traffic",
                   mem_wr, mem_rd);
        end else begin
          x = xfer_q.pop_front();
          check("xfer_kind", {mem_wr, mem_rd}, x.is_wr ? 2'b10 : 2'b01);
          if (x.is_wr) check("wb_waddr", waddr, x.ln);
          else         check("fill_raddr", raddr, x.ln);
        end
      end
      prd = mem_rd;
      pwr = mem_wr;
    end
  end

  initial begin : stimulus
    int unsigned tags [4];
    bit          seen;
    tags = '{0, 1, 'h155, 'hFFF};
    reset = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_adr = '0; cpu_ben = '0; cpu_wdata = '0;
    cache_wdata = '0; cache_en = 1'b0; cache_we = 1'b0; cache_addr = '0;
    rd_busy = 1'b0; wr_busy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_stall", cpu_stall, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_raddr", raddr, 18'h0);
    check("rst_waddr", waddr, 18'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_cache_rdata", cache_rdata, 128'h0);
    reset = 1'b0;

    // Cold load, store-merge hit, conflicting load with write-back, back-to-back hits.
    do_req(1'b1, 1'b0, 'h40, 4'h0, 32'h0);
    do_req(1'b0, 1'b1, 'h41, 4'b0101, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 'h41, 4'h0, 32'h0);
    do_req(1'b1, 1'b0, 'h441, 4'h0, 32'h0);
    check("wb_psram_word", psram_rd('h41), gold_rd('h41));
    for (int w = 0; w < 4; w++) do_req(1'b1, 1'b0, 'h440 + w, 4'h0, 32'h0);

    // Reset in the middle of a fill, during beat 2.
    idle();
    begin
      bit          h;
      logic [31:0] d;
      model_access('h800, 1'b0, 4'h0, 32'h0, h, d);
    end
    @(posedge clk); #1;
    cpu_rd  = 1'b1;
    cpu_adr = 22'h800;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = cache_en && cache_we && (cache_addr == 2'd2);
    end
    check("beat2_reached", seen, 1'b1);
    #1;
    reset  = 1'b1;
    cpu_rd = 1'b0;
    #1;
    check("mid_rst_cpu_stall", cpu_stall, 1'b0);
    check("mid_rst_mem_rd", mem_rd, 1'b0);
    check("mid_rst_raddr", raddr, 18'h0);
    check("mid_rst_cpu_rdata", cpu_rdata, 32'h0);
    check("mid_rst_cache_rdata", cache_rdata, 128'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    do_req(1'b1, 1'b0, 'h800, 4'h0, 32'h0);

    // Randomized mix over four conflicting tags per index.
    for (int k = 0; k < 250; k++) begin
      int unsigned ln, wa, op;
      ln = tags[$urandom_range(0, 3)] * NL + $urandom_range(0, 3);
      wa = ln * 16 + $urandom_range(0, 15);
      op = $urandom_range(0, 9);
      do_req((op < 5) || (op == 9), op >= 5, wa, 4'($urandom), $urandom);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    repeat (5) @(posedge clk);
    #1;
    check("pending_loads", exp_q.size(), 0);
    check("pending_xfers", xfer_q.size(), 0);
    check("rd_wr_overlap", overlap, 0);
`ifdef PSRAM_CACHE_STATS_EN
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
`endif
    finish_run();
  end

endmodule
